// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan driver: panel geometry, the scan
// state encoding and the bit-plane slice helper.
package hub75_pkg;

  localparam int PANEL_WIDTH = 64;
  localparam int SCAN_ROWS   = 16;
  localparam int COL_W       = 6;
  localparam int ROW_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SHIFT      = 3'd1,
    ST_SHIFT_TAIL = 3'd2,
    ST_LATCH      = 3'd3,
    ST_DISPLAY    = 3'd4,
    ST_BLANK      = 3'd5
  } scan_state_t;

  // Picks bit 'plane' (plane 0 = channel LSB) of each colour channel of the
  // top and bottom pixels. Pixels are packed {R,G,B}, zero-extended to 32 bits.
  // Result ordering matches the connector: {R1,G1,B1,R2,G2,B2}.
  function automatic logic [5:0] plane_slice(
    input logic [31:0] top,
    input logic [31:0] bottom,
    input logic [4:0]  colour_bits,
    input logic [4:0]  plane
  );
    logic [4:0] r_idx;
    logic [4:0] g_idx;
    logic [4:0] b_idx;
    b_idx = plane;
    g_idx = colour_bits + plane;
    r_idx = colour_bits + colour_bits + plane;
    plane_slice = {top[r_idx], top[g_idx], top[b_idx],
                   bottom[r_idx], bottom[g_idx], bottom[b_idx]};
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Display-time down-counter for binary-coded modulation: loads
// BASE_TIME << plane and flags the last display cycle.
module hub75_bcm_timer #(
  parameter int BASE_TIME   = 4,
  parameter int COLOUR_BITS = 4,
  parameter int PLANE_W     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  localparam int MAX_TIME = BASE_TIME << (COLOUR_BITS - 1);
  localparam int CNT_W    = $clog2(MAX_TIME + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_value;

  assign load_value = CNT_W'(BASE_TIME) << plane;

  // Count reads N on the first display cycle, so done (count==1) marks the Nth.
  assign done = (count == CNT_W'(1));

  // Load on the latch cycle, then count down once per display cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver: reads top/bottom pixel pairs from the pixel RAM,
// shifts one bit-plane per pass, latches it and shows it for a time weighted
// by plane significance. All panel and RAM outputs are registered; their next
// values are decoded from the next state so they line up with the state.
module hub75_scan_driver #(
  parameter int BITS_PER_PIXEL = 12,
  parameter int COLOUR_BITS    = 4,
  parameter int BASE_TIME      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  output logic [9:0]                read_addr,
  output logic                      read_en,
  input  logic [BITS_PER_PIXEL-1:0] read_data_top,
  input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
  output logic [5:0]                hub75_rgb,
  output logic                      hub75_clk,
  output logic                      hub75_lat,
  output logic                      hub75_oe_n,
  output logic [3:0]                hub75_addr,
  output logic                      frame_done
);

  import hub75_pkg::*;

  localparam int PLANE_W = (COLOUR_BITS > 1) ? $clog2(COLOUR_BITS) : 1;
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(COLOUR_BITS - 1);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(PANEL_WIDTH - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(SCAN_ROWS - 1);

  scan_state_t        state;
  scan_state_t        state_nx;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   row_nx;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   col_nx;
  logic               phase;
  logic               phase_nx;
  logic [PLANE_W-1:0] plane;
  logic [PLANE_W-1:0] plane_nx;

  logic [9:0] read_addr_nx;
  logic       read_en_nx;
  logic       hub75_clk_nx;
  logic       hub75_lat_nx;
  logic       hub75_oe_n_nx;
  logic [3:0] hub75_addr_nx;
  logic       frame_done_nx;

  logic       timer_done;
  logic [5:0] rgb_slice;

  assign rgb_slice = plane_slice(32'(read_data_top), 32'(read_data_bottom),
                                 5'(COLOUR_BITS), 5'(plane));

  hub75_bcm_timer #(
    .BASE_TIME   (BASE_TIME),
    .COLOUR_BITS (COLOUR_BITS),
    .PLANE_W     (PLANE_W)
  ) u_bcm_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == ST_LATCH),
    .run     (state == ST_DISPLAY),
    .plane   (plane),
    .done    (timer_done)
  );

  // Next-state and scan-counter sequencing.
  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    phase_nx = phase;
    plane_nx = plane;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nx = ST_SHIFT;
          row_nx   = '0;
          col_nx   = '0;
          phase_nx = 1'b0;
          plane_nx = '0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!phase) begin
          phase_nx = 1'b1;
        end else begin
          phase_nx = 1'b0;
          if (col == LAST_COL) begin
            col_nx   = '0;
            state_nx = ST_SHIFT_TAIL;
          end else begin
            col_nx = col + COL_W'(1);
          end
        end
      end
      ST_SHIFT_TAIL: state_nx = ST_LATCH;
      ST_LATCH:      state_nx = ST_DISPLAY;
      ST_DISPLAY: begin
        if (timer_done) begin
          state_nx = ST_BLANK;
        end else begin
          state_nx = ST_DISPLAY;
        end
      end
      ST_BLANK: begin
        if (plane == LAST_PLANE) begin
          plane_nx = '0;
          if (row == LAST_ROW) begin
            row_nx   = '0;
            state_nx = enable ? ST_SHIFT : ST_IDLE;
          end else begin
            row_nx   = row + ROW_W'(1);
            state_nx = ST_SHIFT;
          end
        end else begin
          plane_nx = plane + PLANE_W'(1);
          state_nx = ST_SHIFT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        row_nx   = '0;
        col_nx   = '0;
        phase_nx = 1'b0;
        plane_nx = '0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the state.
  always_comb begin
    read_addr_nx  = read_addr;
    read_en_nx    = 1'b0;
    hub75_clk_nx  = 1'b0;
    hub75_lat_nx  = 1'b0;
    hub75_oe_n_nx = 1'b1;
    hub75_addr_nx = hub75_addr;
    frame_done_nx = 1'b0;
    case (state_nx)
      ST_IDLE: read_addr_nx = '0;
      ST_SHIFT: begin
        // read_en stays high through both phases so the captured data is real.
        read_en_nx   = 1'b1;
        read_addr_nx = {row_nx, col_nx};
        hub75_clk_nx = ~phase_nx;
      end
      ST_SHIFT_TAIL: hub75_clk_nx = 1'b1;
      ST_LATCH: begin
        // Row address moves only here, while the panel is blanked.
        hub75_lat_nx  = 1'b1;
        hub75_addr_nx = row_nx;
      end
      ST_DISPLAY: hub75_oe_n_nx = 1'b0;
      ST_BLANK:   frame_done_nx = (row_nx == LAST_ROW) && (plane_nx == LAST_PLANE);
      default:    read_addr_nx = '0;
    endcase
  end

  // State, counters and control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      phase      <= 1'b0;
      plane      <= '0;
      read_addr  <= '0;
      read_en    <= 1'b0;
      hub75_clk  <= 1'b0;
      hub75_lat  <= 1'b0;
      hub75_oe_n <= 1'b1;
      hub75_addr <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      row        <= row_nx;
      col        <= col_nx;
      phase      <= phase_nx;
      plane      <= plane_nx;
      read_addr  <= read_addr_nx;
      read_en    <= read_en_nx;
      hub75_clk  <= hub75_clk_nx;
      hub75_lat  <= hub75_lat_nx;
      hub75_oe_n <= hub75_oe_n_nx;
      hub75_addr <= hub75_addr_nx;
      frame_done <= frame_done_nx;
    end
  end

  // Capture the plane slice in phase 1, when the RAM data for this column is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hub75_rgb <= '0;
    end else if ((state == ST_SHIFT) && phase) begin
      hub75_rgb <= rgb_slice;
    end else begin
      hub75_rgb <= hub75_rgb;
    end
  end

endmodule
